gb_mode_seq: RTL

GB_MODE_SEQ -- requirements
Module: gb_mode_seq

---
 rtl/gb_mode_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gb_mode_seq.sv
// Gearbox mode-change sequencer: drain the datapath, pulse the gearbox reset, settle, then acknowledge.
// Optional macro DDR_GB_SEQ_TIMEOUT_EN aborts a drain that never sees i_idle after TIMEOUT_CYC cycles.
module gb_mode_seq #(
    parameter int RST_CYC     = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic [3:0] i_dwgb,
    input  logic [3:0] i_drgb,
    input  logic [2:0] i_dgb,
    input  logic [3:0] i_fgb,
    input  logic [3:0] i_wgb,
    input  logic       i_idle,
    output logic       o_ack,
    output logic       o_err,
    output logic       o_busy,
    output logic       o_dp_hold,
    output logic       o_dp_rst,
    output logic [3:0] o_dwgb,
    output logic [3:0] o_drgb,
    output logic [2:0] o_dgb,
    output logic [3:0] o_fgb,
    output logic [3:0] o_wgb
);

    typedef enum logic [2:0] {IDLE, DRAIN, RESET, SETTLE, DONE} state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       ack_q, err_q, busy_q, hold_q, dprst_q;
    logic [3:0] dwgb_q, drgb_q, fgb_q, wgb_q;
    logic [2:0] dgb_q;
    logic [3:0] req_dwgb_q, req_drgb_q, req_fgb_q, req_wgb_q;
    logic [2:0] req_dgb_q;
    logic       req_legal_d;

    // Codes 1 and 3 are unsupported DFI write ratios; every datapath code is valid.
    always_comb begin
        req_legal_d = !((i_dwgb == 4'd1) || (i_dwgb == 4'd3) || (i_dwgb > 4'd8) ||
                        (i_drgb > 4'd9) || (i_fgb > 4'd10) || (i_wgb > 4'd10));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
            dprst_q    <= 1'b0;
            dwgb_q     <= '0;
            drgb_q     <= '0;
            dgb_q      <= '0;
            fgb_q      <= '0;
            wgb_q      <= '0;
            req_dwgb_q <= '0;
            req_drgb_q <= '0;
            req_dgb_q  <= '0;
            req_fgb_q  <= '0;
            req_wgb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        req_dwgb_q <= i_dwgb;
                        req_drgb_q <= i_drgb;
                        req_dgb_q  <= i_dgb;
                        req_fgb_q  <= i_fgb;
                        req_wgb_q  <= i_wgb;
                        busy_q     <= 1'b1;
                        if (req_legal_d) begin
                            state_q <= DRAIN;
                            hold_q  <= 1'b1;
                            cnt_q   <= 8'(TIMEOUT_CYC - 1);
                        end else begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_idle) begin
                        state_q <= RESET;
                        dprst_q <= 1'b1;
                        cnt_q   <= 8'(RST_CYC - 1);
                        dwgb_q  <= req_dwgb_q;
                        drgb_q  <= req_drgb_q;
                        dgb_q   <= req_dgb_q;
                        fgb_q   <= req_fgb_q;
                        wgb_q   <= req_wgb_q;
`ifdef DDR_GB_SEQ_TIMEOUT_EN
                    end else if (cnt_q == 8'd0) begin
                        state_q <= DONE;
                        hold_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
`else
                    // Without the abort the counter just parks at zero while waiting.
                    end else if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end
`endif
                end
                RESET: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= SETTLE;
                        dprst_q <= 1'b0;
                        cnt_q   <= 8'(SETTLE_CYC - 1);
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= DONE;
                        hold_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    if (!i_req) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_busy    = busy_q;
    assign o_dp_hold = hold_q;
    assign o_dp_rst  = dprst_q;
    assign o_dwgb    = dwgb_q;
    assign o_drgb    = drgb_q;
    assign o_dgb     = dgb_q;
    assign o_fgb     = fgb_q;
    assign o_wgb     = wgb_q;

endmodule
